// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake turn scheduler.
// Directions are 4-bit one-hot: UP=bit0, DOWN=bit1, LEFT=bit2, RIGHT=bit3.
package snake_pkg;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_RESET = DIR_RIGHT;

    // Swap UP<->DOWN and LEFT<->RIGHT.
    function automatic logic [3:0] opposite_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/snake_turn_scheduler_fifo.sv
// Pending-turn FIFO; occupancy counter drives full/empty so that
// pointer equality is never ambiguous.
module turn_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;
    logic             w_wr;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A write into a full FIFO is only legal when the head leaves this cycle.
    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/snake_turn_scheduler.sv
// Keyboard turn sequencer: sync + edge-detect key codes, filter, queue, one turn per step.
// Define SNAKE_REVERSE_BLOCK_EN to also drop turns opposite to the last accepted direction.
module snake_turn_scheduler
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [3:0]             key_in,
    input  logic                   step,
    input  logic                   restart,
    output logic [3:0]             dir,
    output logic                   dir_changed,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   dropped
);

    logic [3:0] r_key_s1, r_key_s2, r_key_s3;
    logic [3:0] r_last_dir;
    logic [3:0] r_dir;
    logic       r_dir_changed;
    logic       r_dropped;

    logic [3:0] w_head;
    logic       w_full, w_empty;
    logic       w_ev_valid;
    logic       w_pop, w_push, w_drop;
    logic       w_rep, w_rev, w_no_room, w_reject;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_key_s1 <= DIR_NONE;
            r_key_s2 <= DIR_NONE;
            r_key_s3 <= DIR_NONE;
        end else begin
            r_key_s1 <= key_in;
            r_key_s2 <= r_key_s1;
            r_key_s3 <= r_key_s2;
        end
    end

    assign w_ev_valid = is_onehot4(r_key_s2) && (r_key_s2 != r_key_s3);
    assign w_pop      = step && !w_empty && !restart;

    assign w_rep = (r_key_s2 == r_last_dir);
`ifdef SNAKE_REVERSE_BLOCK_EN
    assign w_rev = (r_key_s2 == opposite_dir(r_last_dir));
`else
    assign w_rev = 1'b0;
`endif
    // Room is judged after this cycle's pop, so a full FIFO accepts on a step.
    assign w_no_room = w_full && !w_pop;
    assign w_reject  = w_rep || w_rev || w_no_room;
    assign w_push    = w_ev_valid && !w_reject && !restart;
    assign w_drop    = w_ev_valid &&  w_reject && !restart;

    turn_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (restart),
        .i_din   (r_key_s2),
        .o_head  (w_head),
        .o_count (pending),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last_dir    <= DIR_RESET;
            r_dir         <= DIR_RESET;
            r_dir_changed <= 1'b0;
            r_dropped     <= 1'b0;
        end else if (restart) begin
            r_last_dir    <= DIR_RESET;
            r_dir         <= DIR_RESET;
            r_dir_changed <= 1'b0;
            r_dropped     <= 1'b0;
        end else begin
            if (w_push) r_last_dir <= r_key_s2;
            if (w_pop)  r_dir      <= w_head;
            r_dir_changed <= w_pop;
            r_dropped     <= w_drop;
        end
    end

    assign dir         = r_dir;
    assign dir_changed = r_dir_changed;
    assign dropped     = r_dropped;

endmodule

// File: tb/tb_snake_turn_scheduler.sv
// Directed bench for snake_turn_scheduler (DEPTH=4); expectations hand-computed.
module tb_snake_turn_scheduler;

    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] key_in;
    logic       step;
    logic       restart;
    logic [3:0] dir;
    logic       dir_changed;
    logic [2:0] pending;
    logic       dropped;

    int n_cmp = 0;
    int n_err = 0;

    snake_turn_scheduler #(.DEPTH(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .key_in      (key_in),
        .step        (step),
        .restart     (restart),
        .dir         (dir),
        .dir_changed (dir_changed),
        .pending     (pending),
        .dropped     (dropped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a key; the event lands on the third edge, optionally with a step there.
    task automatic press(input logic [3:0] k, input logic stp);
        key_in = k;
        tick();
        tick();
        step = stp;
        tick();
        step = 1'b0;
    endtask

    task automatic do_step(input string tag, input logic [3:0] exp_dir, input logic exp_chg);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk({tag, "_dir"}, 32'(dir), 32'(exp_dir));
        chk({tag, "_chg"}, 32'(dir_changed), 32'(exp_chg));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; key_in = 4'b0000; step = 1'b0; restart = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("rst_dir", 32'(dir), 32'h8);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_chg", 32'(dir_changed), 32'd0);
        chk("rst_drop", 32'(dropped), 32'd0);

        do_step("step_empty", 4'b1000, 1'b0);

        // basic turn
        press(4'b0001, 1'b0);
        chk("basic_pend", 32'(pending), 32'd1);
        chk("basic_drop", 32'(dropped), 32'd0);
        do_step("basic", 4'b0001, 1'b1);
        tick();
        chk("basic_chg_off", 32'(dir_changed), 32'd0);
        chk("basic_pend0", 32'(pending), 32'd0);

        // reversal from RIGHT
        do_restart();
        chk("rs1_dir", 32'(dir), 32'h8);
        press(4'b0100, 1'b0);
`ifdef SNAKE_REVERSE_BLOCK_EN
        chk("rev_drop", 32'(dropped), 32'd1);
        chk("rev_pend", 32'(pending), 32'd0);
        tick();
        chk("rev_drop_off", 32'(dropped), 32'd0);
`else
        chk("rev_drop", 32'(dropped), 32'd0);
        chk("rev_pend", 32'(pending), 32'd1);
        do_step("rev", 4'b0100, 1'b1);
`endif
        do_restart();

        // repeat of last_dir
        press(4'b1000, 1'b0);
        chk("rep_drop", 32'(dropped), 32'd1);
        chk("rep_pend", 32'(pending), 32'd0);
        tick();
        chk("rep_drop_off", 32'(dropped), 32'd0);

        // transients
        press(4'b0011, 1'b0);
        chk("multi_drop", 32'(dropped), 32'd0);
        chk("multi_pend", 32'(pending), 32'd0);
        press(4'b0000, 1'b0);
        chk("zero_drop", 32'(dropped), 32'd0);
        chk("zero_pend", 32'(pending), 32'd0);

        // double tap
        press(4'b0001, 1'b0);
        press(4'b0100, 1'b0);
        chk("dbl_pend", 32'(pending), 32'd2);
        do_step("dbl1", 4'b0001, 1'b1);
        do_step("dbl2", 4'b0100, 1'b1);
        chk("dbl_pend0", 32'(pending), 32'd0);

        // overflow
        do_restart();
        press(4'b0001, 1'b0); chk("ov_p1", 32'(pending), 32'd1);
        press(4'b0100, 1'b0); chk("ov_p2", 32'(pending), 32'd2);
        press(4'b0010, 1'b0); chk("ov_p3", 32'(pending), 32'd3);
        press(4'b1000, 1'b0); chk("ov_p4", 32'(pending), 32'd4);
        press(4'b0001, 1'b0);
        chk("ov_drop", 32'(dropped), 32'd1);
        chk("ov_pend", 32'(pending), 32'd4);

        // push into full FIFO on a step cycle is accepted
        press(4'b0010, 1'b1);
        chk("fullstep_pend", 32'(pending), 32'd4);
        chk("fullstep_dir", 32'(dir), 32'h1);
        chk("fullstep_chg", 32'(dir_changed), 32'd1);
        chk("fullstep_drop", 32'(dropped), 32'd0);
        do_step("pre_rs", 4'b0100, 1'b1);
        chk("pre_rs_pend", 32'(pending), 32'd3);

        // restart with pending 3
        do_restart();
        chk("rs_pend", 32'(pending), 32'd0);
        chk("rs_dir", 32'(dir), 32'h8);
        chk("rs_chg", 32'(dir_changed), 32'd0);

        // simultaneous push and pop with pending 1
        press(4'b0001, 1'b0);
        chk("sim_pend1", 32'(pending), 32'd1);
        press(4'b0100, 1'b1);
        chk("sim_pend", 32'(pending), 32'd1);
        chk("sim_dir", 32'(dir), 32'h1);
        chk("sim_chg", 32'(dir_changed), 32'd1);
        do_step("sim2", 4'b0100, 1'b1);

        // push into empty with same-cycle step is not consumed
        press(4'b0010, 1'b1);
        chk("emp_pend", 32'(pending), 32'd1);
        chk("emp_dir", 32'(dir), 32'h4);
        chk("emp_chg", 32'(dir_changed), 32'd0);
        do_step("emp2", 4'b0010, 1'b1);

        // async reset mid-fill
        press(4'b0100, 1'b0);
        press(4'b0001, 1'b0);
        chk("mid_pend", 32'(pending), 32'd2);
        #2 resetn = 1'b0;
        #1;
        chk("arst_dir", 32'(dir), 32'h8);
        chk("arst_pend", 32'(pending), 32'd0);
        chk("arst_chg", 32'(dir_changed), 32'd0);
        chk("arst_drop", 32'(dropped), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snake_turn_scheduler.md
# snake_turn_scheduler

Sequences keyboard direction requests into the snake game's movement logic. Samples the 4-bit one-hot direction code from the PS/2 keyboard decoder in the system clock domain and detects new key events. Rejects null and reversing turns, buffers accepted turns in a small FIFO, and releases one turn per game step. A quick double-tap between ticks is therefore never lost and never reverses the snake into itself.

## Interface
- DEPTH, 4: pending-turn FIFO entries; power of two, 2..16
- clock  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- key_in  in  4  one-hot direction from keyboard decoder (UP=0001, DOWN=0010, LEFT=0100, RIGHT=1000, 0=none); asynchronous to clock
- step  in  1  one-cycle game-tick pulse; consume one pending turn
- restart  in  1  synchronous flush: empty FIFO, direction back to RIGHT
- dir  out  4  current movement direction, one-hot
- dir_changed  out  1  one-cycle pulse when dir took a new value on a step
- pending  out  $clog2(DEPTH)+1  number of queued turns
- dropped  out  1  one-cycle pulse when a key event was discarded

## Operation
- Input sync: key_in → key_s1 → key_s2 (two flops), key_s3 = previous key_s2.
- Key event: key_s2 is exactly one-hot AND key_s2 != key_s3. Zero or multi-bit codes (decoder transients, releases) are ignored and do not count as drops.
- last_dir register: equals the FIFO tail if pending>0, else dir. Reset and restart set it to RIGHT.
- Event acceptance, in priority order:
  - ev == last_dir: drop.
  - ev == opposite(last_dir): drop.
  - FIFO full after this cycle's pop: drop the newest event; existing entries are kept.
  - Otherwise: push ev and set last_dir = ev.
- Step with pending>0 (pre-push count): pop head, dir ← head, dir_changed=1. Step with FIFO empty: no change, dir_changed=0.
- Simultaneous push and pop: both occur, and pending is unchanged. A push into an empty FIFO is not consumed by the same-cycle step; it is popped on the next step.
- restart overrides step and any event in the same cycle. FIFO is cleared, dir=last_dir=RIGHT, and no pulses are generated. key_s3 is still updated, so a held key does not re-fire.
- Entries in the FIFO are never reversals of their predecessor, so popping needs no recheck.

## Timing
- Reset values: dir=1000, last_dir=1000, pending=0, dir_changed=0, dropped=0, sync flops=0, FIFO pointers=0.
- key_in change → event visible after 2nd clock edge → push/dropped on 3rd edge. pending updates after the 3rd edge.
- step sampled at edge N → dir and dir_changed valid after edge N; dir_changed deasserts at edge N+1.
- dropped is registered and high for exactly one cycle per rejected event.
- step is assumed to be a single-cycle pulse. A multi-cycle step pops once per high cycle.
- Pointer wrap: modulo DEPTH. The full flag is derived from the count, not from pointer equality alone.

## Configuration
- SNAKE_REVERSE_BLOCK_EN defined: opposite-direction events are dropped as described above.
- Not defined: opposite-direction events are accepted and queued; only repeats of last_dir are dropped. The game's collision logic then handles self-reversal.

## Structure
- Shared package snake_pkg:
  - direction constants DIR_UP/DOWN/LEFT/RIGHT (4-bit one-hot), DIR_NONE, DIR_RESET=DIR_RIGHT
  - function opposite_dir (swaps UP↔DOWN, LEFT↔RIGHT)
  - function is_onehot4
- Sub-module turn_fifo, parameterised DEPTH and WIDTH=4:
  - inputs push, pop, clear; outputs head, count, full, empty
  - async active-low reset; same-cycle push and pop are legal
- Top level holds the synchronizer, event detect, last_dir, acceptance logic and the dir register.

## Test plan
- Reset: after resetn deasserts, dir=1000 and pending=0. step with no key leaves dir=1000 and dir_changed=0.
- Basic turn: key_in=0001 → pending=1 three cycles later; step → dir=0001 with a one-cycle dir_changed.
- Reversal: dir=1000, key_in=0100 → dropped pulse and pending stays 0 with the macro defined. Without the macro, pending=1 and the next step gives dir=0100.
- Double-tap: dir=1000, keys 0001 then 0100 before any step → pending=2. Two steps give dir=0001, then 0100.
- Overflow and transients:
  - DEPTH=4, alternate 0001/0100/0010… to fill: the 5th valid event is dropped and pending stays 4.
  - key_in=0011 or 0000 → no event and no dropped pulse.
- Simultaneous and restart:
  - push on the step cycle with pending=1 → head pops and pending stays 1.
  - restart with pending=3 → pending=0 and dir=1000 next cycle.
  - resetn asserted mid-fill → all outputs are at their reset values immediately.
